// File: rtl/hbm_pkg.sv
// Shared types and constants for the HBM pseudo-channel responder.
// Word layout is lane-packed: lane 0 occupies bits [15:0].
package hbm_pkg;

    localparam int HBM_LANES  = 16;
    localparam int HBM_LANE_W = 16;

    // Field widths carried inside the request/response structs; the top-level
    // ADDR_W and ID_W parameters must not exceed these.
    localparam int HBM_ADDR_W = 16;
    localparam int HBM_ID_W   = 4;

    typedef logic [HBM_LANES-1:0][HBM_LANE_W-1:0] hbm_word_t;

    typedef struct packed {
        logic                  we;
        logic [HBM_ADDR_W-1:0] addr;
        logic [HBM_ID_W-1:0]   id;
        hbm_word_t             wdata;
        logic [HBM_LANES-1:0]  wmask;
    } hbm_req_t;

    typedef struct packed {
        logic                we;
        logic [HBM_ID_W-1:0] id;
        logic                err;
        hbm_word_t           rdata;
    } hbm_rsp_t;

    // Lane-wise merge: lanes with the mask bit set take the new value.
    function automatic hbm_word_t hbm_merge(input hbm_word_t            old_w,
                                            input hbm_word_t            new_w,
                                            input logic [HBM_LANES-1:0] mask);
        hbm_word_t res;
        res = old_w;
        for (int l = 0; l < HBM_LANES; l++) begin
            if (mask[l]) begin
                res[l] = new_w[l];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hbm_rsp_fifo.sv
// Synchronous response FIFO. The head entry is presented combinationally
// from the storage registers and forced to zero while the FIFO is empty, so
// the response outputs read as zero after reset without clearing storage.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module hbm_rsp_fifo
    import hbm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     CLK_i,
    input  logic     RST_i,
    input  logic     push_i,
    input  hbm_rsp_t push_data_i,
    input  logic     pop_i,
    output hbm_rsp_t head_o,
    output logic     valid_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    hbm_rsp_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge CLK_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RST_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; when full, push and pop target the same slot, and the
    // old head is still read out during that cycle.
    always_ff @(posedge CLK_i) begin
        // NOTE: storage is deliberately not reset; validity is tracked by count_q alone.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head presentation.
    always_comb begin
        valid_o = (count_q != '0);
        head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/hbm_channel_responder.sv
// Memory-side responder for one HBM pseudo-channel: banked word store,
// fixed-latency response pipeline, credit counter and response FIFO.
// Optional macro HBM_RSP_PERF_EN adds read/write/stall saturating counters.
// Latency: the pipeline has RD_LAT-1 stages and the FIFO head adds one more,
// so a request accepted in cycle T is visible at T+RD_LAT (RD_LAT >= 2).
module hbm_channel_responder
    import hbm_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 4,
    parameter int RSP_DEPTH = 8,
    parameter int ID_W      = 4
) (
    input  logic                                 CLK_i,
    input  logic                                 RST_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_we_i,
    input  logic [ADDR_W-1:0]                    req_addr_i,
    input  logic [ID_W-1:0]                      req_id_i,
    input  logic [HBM_LANES-1:0][HBM_LANE_W-1:0] req_wdata_i,
    input  logic [HBM_LANES-1:0]                 req_wmask_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic                                 rsp_we_o,
    output logic [ID_W-1:0]                      rsp_id_o,
    output logic                                 rsp_err_o,
    output logic [HBM_LANES-1:0][HBM_LANE_W-1:0] rsp_rdata_o
`ifdef HBM_RSP_PERF_EN
    ,
    output logic [31:0]                          perf_rd_o,
    output logic [31:0]                          perf_wr_o,
    output logic [31:0]                          perf_stall_o
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NSTG  = RD_LAT - 1;
    localparam int OUT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [HBM_ADDR_W:0] DEPTH_X = (HBM_ADDR_W + 1)'(DEPTH);

    hbm_req_t         req;
    hbm_rsp_t         in_rsp;
    logic             in_err;
    logic [IDX_W-1:0] store_idx;
    logic             acc;
    logic             pop;

    hbm_word_t        store_mem [DEPTH];

    hbm_rsp_t         pipe_q [NSTG];
    hbm_rsp_t         pipe_d [NSTG];
    logic [NSTG-1:0]  pipe_vld_q, pipe_vld_d;

    logic [OUT_W-1:0] outstanding_q, outstanding_d;

    hbm_rsp_t         head;

    // Bundle the request, decode range and form the stage-0 response.
    always_comb begin
        req.we    = req_we_i;
        req.addr  = HBM_ADDR_W'(req_addr_i);
        req.id    = HBM_ID_W'(req_id_i);
        req.wdata = req_wdata_i;
        req.wmask = req_wmask_i;

        in_err    = ({1'b0, req.addr} >= DEPTH_X);
        store_idx = req.addr[IDX_W-1:0];
        acc       = req_valid_i && req_ready_o;

        in_rsp.we    = req.we;
        in_rsp.id    = req.id;
        in_rsp.err   = in_err;
        in_rsp.rdata = '0;
        if (!req.we && !in_err) begin
            in_rsp.rdata = store_mem[store_idx];
        end
    end

    // Word store: masked lanes are written at the end of the acceptance cycle.
    always_ff @(posedge CLK_i) begin
        if (acc && req.we && !in_err) begin
            store_mem[store_idx] <= hbm_merge(store_mem[store_idx], req.wdata, req.wmask);
        end
    end

    // Latency pipeline shift: stage 0 captures the accepted request.
    always_comb begin
        pipe_vld_d[0] = acc;
        pipe_d[0]     = in_rsp;
        for (int s = 1; s < NSTG; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_d[s]     = pipe_q[s-1];
        end
    end

    // Pipeline valid bits are control state and are cleared by reset.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Pipeline payload only matters where the matching valid bit is set.
    always_ff @(posedge CLK_i) begin
        pipe_q <= pipe_d;
    end

    // Credit counter: pipeline entries are counted from acceptance, so the
    // FIFO can never be pushed beyond RSP_DEPTH.
    always_comb begin
        req_ready_o   = (outstanding_q < OUT_W'(RSP_DEPTH));
        pop           = rsp_valid_o && rsp_ready_i;
        outstanding_d = outstanding_q;
        case ({acc, pop})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding-request register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    hbm_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .push_i      (pipe_vld_q[NSTG-1]),
        .push_data_i (pipe_q[NSTG-1]),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (rsp_valid_o)
    );

    // Response outputs straight from the FIFO head.
    always_comb begin
        rsp_we_o    = head.we;
        rsp_id_o    = ID_W'(head.id);
        rsp_err_o   = head.err;
        rsp_rdata_o = head.rdata;
    end

`ifdef HBM_RSP_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters.
    always_comb begin
        perf_rd_d    = perf_rd_q;
        perf_wr_d    = perf_wr_q;
        perf_stall_d = perf_stall_q;
        if (acc && !req.we && (perf_rd_q != '1)) begin
            perf_rd_d = perf_rd_q + 32'd1;
        end
        if (acc && req.we && (perf_wr_q != '1)) begin
            perf_wr_d = perf_wr_q + 32'd1;
        end
        if (req_valid_i && !req_ready_o && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_rd_o    = perf_rd_q;
    assign perf_wr_o    = perf_wr_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_hbm_channel_responder.sv
// Directed + random bench for hbm_channel_responder with a transaction-level
// reference model (associative word store and an ordered queue of expected
// responses stamped with their acceptance cycle).
module tb_hbm_channel_responder;
    import hbm_pkg::*;

    localparam int DEPTH     = 4096;
    localparam int RD_LAT    = 4;
    localparam int RSP_DEPTH = 8;

    logic            CLK_i = 1'b0;
    logic            RST_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [15:0]     req_addr_i = '0;
    logic [3:0]      req_id_i = '0;
    hbm_word_t       req_wdata_i = '0;
    logic [15:0]     req_wmask_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b1;
    logic            rsp_we_o;
    logic [3:0]      rsp_id_o;
    logic            rsp_err_o;
    hbm_word_t       rsp_rdata_o;
`ifdef HBM_RSP_PERF_EN
    logic [31:0]     perf_rd_o, perf_wr_o, perf_stall_o;
`endif

    hbm_channel_responder #(
        .DEPTH(DEPTH), .ADDR_W(16), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH), .ID_W(4)
    ) dut (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_id_i    (req_id_i),
        .req_wdata_i (req_wdata_i),
        .req_wmask_i (req_wmask_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_we_o    (rsp_we_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_rdata_o (rsp_rdata_o)
`ifdef HBM_RSP_PERF_EN
        ,
        .perf_rd_o    (perf_rd_o),
        .perf_wr_o    (perf_wr_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        int         t;
        logic       we;
        logic [3:0] id;
        logic       err;
        hbm_word_t  rdata;
    } exp_t;

    exp_t      exp_q[$];
    hbm_word_t ref_mem[int];
    int        total = 0;
    int        bad   = 0;
    int        cyc   = 0;
    int        n_rd  = 0;
    int        n_wr  = 0;
    int        n_stall = 0;
    bit        rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check cycle-level behaviour, update the model with
    // whatever handshakes happen at the coming edge, then advance.
    task automatic tick();
        logic acc, pop;
        exp_t e;
        hbm_word_t w;
        int a;
        if (rand_rdy) rsp_ready_i = 1'($urandom_range(1));
        acc = req_valid_i && req_ready_o;
        pop = rsp_valid_o && rsp_ready_i;
        check("ready", req_ready_o, exp_q.size() < RSP_DEPTH);
        check("valid", rsp_valid_o, exp_q.size() != 0 && cyc >= exp_q[0].t + RD_LAT);
        if (pop && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp", {rsp_we_o, rsp_id_o, rsp_err_o, rsp_rdata_o}, {e.we, e.id, e.err, e.rdata});
        end
        if (acc) begin
            a       = int'(req_addr_i);
            e.t     = cyc;
            e.we    = req_we_i;
            e.id    = req_id_i;
            e.err   = (a >= DEPTH);
            e.rdata = '0;
            if (req_we_i) n_wr++; else n_rd++;
            if (!e.err) begin
                if (req_we_i) begin
                    w = ref_mem.exists(a) ? ref_mem[a] : '0;
                    for (int l = 0; l < HBM_LANES; l++)
                        if (req_wmask_i[l]) w[l] = req_wdata_i[l];
                    ref_mem[a] = w;
                end else begin
                    e.rdata = ref_mem.exists(a) ? ref_mem[a] : '0;
                end
            end
            exp_q.push_back(e);
        end
        if (req_valid_i && !req_ready_o) n_stall++;
        @(posedge CLK_i);
        #1;
        cyc++;
    endtask

    // Present one request and hold it until accepted; valid stays high after.
    task automatic issue(input logic we, input int addr, input int id,
                         input hbm_word_t wd, input logic [15:0] mask);
        logic ok, a;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = 16'(addr);
        req_id_i    = 4'(id);
        req_wdata_i = wd;
        req_wmask_i = mask;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a = req_ready_o;
            tick();
            if (a) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_accepted", ok, 1'b1);
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        req_valid_i = 1'b0;
        RST_i = 1'b1;
        repeat (n) begin
            @(posedge CLK_i);
            #1;
            cyc++;
        end
        exp_q.delete();
        n_rd = 0;
        n_wr = 0;
        n_stall = 0;
    endtask

    function automatic hbm_word_t fill(input logic [15:0] v);
        hbm_word_t w;
        for (int l = 0; l < HBM_LANES; l++) w[l] = v;
        return w;
    endfunction

    function automatic hbm_word_t rand_word();
        hbm_word_t w;
        for (int l = 0; l < HBM_LANES; l++) w[l] = 16'($urandom);
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        hbm_word_t lanes_idx;
        int        n_acc;
        logic      a;
        int        pool[16];
        int        addr;

        // Reset values
        do_reset(3);
        check("rst_ready", req_ready_o, 1'b1);
        check("rst_valid", rsp_valid_o, 1'b0);
        check("rst_fields", {rsp_we_o, rsp_id_o, rsp_err_o, rsp_rdata_o}, '0);
`ifdef HBM_RSP_PERF_EN
        check("rst_perf", {perf_rd_o, perf_wr_o, perf_stall_o}, '0);
`endif
        RST_i = 1'b0;
        rsp_ready_i = 1'b1;

        // 1: write then read-after-write at T+1
        issue(1'b1, 16'h010, 3, fill(16'h1234), 16'hFFFF);
        issue(1'b0, 16'h010, 4, '0, 16'h0000);
        idle();
        drain();

        // 2: partial mask over prior contents
        for (int l = 0; l < HBM_LANES; l++) lanes_idx[l] = 16'(l);
        issue(1'b1, 16'h010, 5, lanes_idx, 16'h00F0);
        issue(1'b0, 16'h010, 6, '0, 16'h0000);
        idle();
        drain();

        // 3: credit exhaustion under backpressure
        rsp_ready_i = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            req_valid_i = 1'b1;
            req_we_i    = 1'b0;
            req_addr_i  = 16'h010;
            req_id_i    = 4'(n_acc);
            a = req_ready_o;
            tick();
            if (a) n_acc++;
        end
        check("t3_accepts", n_acc, RSP_DEPTH);
        check("t3_ready_low", req_ready_o, 1'b0);
        idle();
        rsp_ready_i = 1'b1;
        drain();
        check("t3_ready_back", req_ready_o, 1'b1);

        // 4: out-of-range access leaves the store alone
        issue(1'b1, 0, 7, fill(16'hA5A5), 16'hFFFF);
        issue(1'b0, DEPTH, 8, '0, 16'h0000);
        issue(1'b1, DEPTH, 9, fill(16'hDEAD), 16'hFFFF);
        issue(1'b0, 0, 10, '0, 16'h0000);
        idle();
        drain();

        // 5: reset with requests in flight
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b0, 16'h010, 11 + i, '0, 16'h0000);
        idle();
        do_reset(1);
        check("t5_valid", rsp_valid_o, 1'b0);
        check("t5_ready", req_ready_o, 1'b1);
        RST_i = 1'b0;
        rsp_ready_i = 1'b1;
        issue(1'b0, 16'h010, 1, '0, 16'h0000);
        issue(1'b0, 0, 2, '0, 16'h0000);
        idle();
        drain();

        // 6: random traffic
        pool[0] = 0;
        pool[1] = 16'h010;
        for (int i = 2; i < 16; i++) pool[i] = int'($urandom_range(DEPTH - 1));
        for (int i = 2; i < 16; i++) issue(1'b1, pool[i], i, rand_word(), 16'hFFFF);
        idle();
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(9) == 0) addr = int'($urandom_range(65535, DEPTH));
            else addr = pool[$urandom_range(15)];
            issue(1'($urandom_range(1)), addr, int'($urandom_range(15)),
                  rand_word(), 16'($urandom));
            if ($urandom_range(3) == 0) begin
                idle();
                tick();
            end
        end
        idle();
        rand_rdy = 1'b0;
        rsp_ready_i = 1'b1;
        drain();
`ifdef HBM_RSP_PERF_EN
        check("perf_rd", perf_rd_o, n_rd);
        check("perf_wr", perf_wr_o, n_wr);
        check("perf_stall", perf_stall_o, n_stall);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
